// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game control slice.
//   state_t      - encoding of the per-frame sequencer states
//   dir_t        - character direction / action codes used by the datapath
//   ON / OFF     - strobe level constants
//   strobes_t    - the Moore strobe bundle, and decode_strobes() which maps
//                  a state onto it
package game_pkg;

  typedef enum logic [3:0] {
    S_WAIT_START = 4'd0,
    S_INIT       = 4'd1,
    S_IDLE       = 4'd2,
    S_DRAW_MAP   = 4'd3,
    S_REG        = 4'd4,
    S_COLL       = 4'd5,
    S_APPLY      = 4'd6,
    S_SETTLE     = 4'd7,
    S_DRAW_LINK  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    NO_ACTION = 3'd0,
    ATTACK    = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5
  } dir_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef struct packed {
    logic init;
    logic idle;
    logic draw_map;
    logic reg_action;
    logic apply_action;
    logic draw_link;
    logic vga_sel;
  } strobes_t;

  // vga_sel follows draw_link: the character source is selected only while
  // the character is being drawn, the map source at every other time.
  function automatic strobes_t decode_strobes(input state_t s);
    strobes_t o;
    o = '0;
    case (s)
      S_INIT:      o.init         = ON;
      S_IDLE:      o.idle         = ON;
      S_DRAW_MAP:  o.draw_map     = ON;
      S_REG:       o.reg_action   = ON;
      S_APPLY:     o.apply_action = ON;
      S_DRAW_LINK: begin
        o.draw_link = ON;
        o.vga_sel   = ON;
      end
      default:     o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// game_ctrl_fsm_if: bundle between the frame sequencer and its neighbours
// (frame-tick generator, map renderer, character datapath, VGA mux).
//   master - the sequencer: consumes start/tick/done, drives strobes/status
//   slave  - the surrounding blocks
//
// Signalling: there is no valid/ready pairing here. start is a level sampled
// only while waiting to start; frame_tick is a one-cycle pulse; the two
// *_draw_done inputs are levels that rise when their draw completes and may
// linger one cycle after the matching enable drops. Every output is a
// registered Moore signal.
interface game_ctrl_fsm_if;
  logic       start;
  logic       frame_tick;
  logic       map_draw_done;
  logic       link_draw_done;
  logic       init;
  logic       idle;
  logic       draw_map;
  logic       reg_action;
  logic       apply_action;
  logic       draw_link;
  logic       vga_sel;
  logic [7:0] frame_count;
  logic       timeout_err;
  logic       frame_overrun;

  modport master (
    input  start, frame_tick, map_draw_done, link_draw_done,
    output init, idle, draw_map, reg_action, apply_action, draw_link,
           vga_sel, frame_count, timeout_err, frame_overrun
  );

  modport slave (
    output start, frame_tick, map_draw_done, link_draw_done,
    input  init, idle, draw_map, reg_action, apply_action, draw_link,
           vga_sel, frame_count, timeout_err, frame_overrun
  );
endinterface

// File: rtl/game_ctrl_fsm_frame_pacer.sv
// frame_pacer: remembers a frame_tick that arrives while the sequencer is
// busy, flags a second one as an overrun, and divides frames down to
// movement steps.
//   clock, reset   - clock, async active-low reset
//   clear          - sequencer is initialising: drop all pacing state
//   in_idle        - sequencer is idle; a tick here is consumed directly
//   frame_tick     - one pulse per VGA frame
//   map_exit       - sequencer is leaving the map draw this cycle
//   pending        - a tick is waiting to start the next frame
//   frame_overrun  - sticky: a tick arrived while one was already pending
//   move_frame     - the current frame carries a movement step
module frame_pacer
  import game_pkg::*;
#(
  parameter int unsigned MOVE_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic in_idle,
  input  logic frame_tick,
  input  logic map_exit,
  output logic pending,
  output logic frame_overrun,
  output logic move_frame
);

  localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;

  always_comb begin
    div_d     = div_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clear) begin
      div_d     = '0;
      pending_d = OFF;
      overrun_d = OFF;
    end else begin
      // In idle a pending tick or a fresh tick always launches a frame, so
      // nothing remains pending on the following cycle.
      if (in_idle) begin
        pending_d = OFF;
      end else if (frame_tick) begin
        if (pending_q) overrun_d = ON;
        pending_d = ON;
      end
      if (map_exit) begin
        div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      pending_q <= OFF;
      overrun_q <= OFF;
    end else begin
      div_q     <= div_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending       = pending_q;
  assign frame_overrun = overrun_q;
  assign move_frame    = (div_q == DIV_LAST);

endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: once-per-frame sequencer for the map renderer and the Link
// character datapath: map redraw, optional movement step (latch command,
// collision settle, apply, sprite RAM settle), then character redraw.
//   clock, reset - clock, async active-low reset
//   bus          - game_ctrl_fsm_if.master (inputs start, frame_tick,
//                  map_draw_done, link_draw_done; strobes, vga_sel,
//                  frame_count and sticky error flags out)
//   dbg_state    - current state register, for observation
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned MOVE_DIV     = 2,
  parameter int unsigned DRAW_TIMEOUT = 131071,
  parameter int unsigned TO_W         = 17
) (
  input  logic            clock,
  input  logic            reset,
  game_ctrl_fsm_if.master bus,
  output state_t          dbg_state
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAW_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  strobes_t        strobes_q, strobes_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            timeout_err_q, timeout_err_d;

  logic pending;
  logic move_frame;
  logic map_exit;
  logic timeout_hit;

  frame_pacer #(
    .MOVE_DIV (MOVE_DIV)
  ) u_pacer (
    .clock         (clock),
    .reset         (reset),
    .clear         (state_q == S_INIT),
    .in_idle       (state_q == S_IDLE),
    .frame_tick    (bus.frame_tick),
    .map_exit      (map_exit),
    .pending       (pending),
    .frame_overrun (bus.frame_overrun),
    .move_frame    (move_frame)
  );

  // The counter holds (cycles spent in the draw state - 1), so a hit on
  // DRAW_TIMEOUT-1 leaves after exactly DRAW_TIMEOUT cycles. It is zero in
  // every non-draw state, which makes it zero on entry to a draw state.
  assign timeout_hit = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = '0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    map_exit      = OFF;
    case (state_q)
      S_WAIT_START: if (bus.start) state_d = S_INIT;
      S_INIT: begin
        frame_count_d = '0;
        timeout_err_d = OFF;
        state_d       = S_IDLE;
      end
      S_IDLE: if (bus.frame_tick || pending) state_d = S_DRAW_MAP;
      S_DRAW_MAP: begin
        if (bus.map_draw_done || timeout_hit) begin
          map_exit = ON;
          state_d  = move_frame ? S_REG : S_DRAW_LINK;
          // A done arriving together with the timeout is a normal finish.
          if (!bus.map_draw_done) timeout_err_d = ON;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_REG:    state_d = S_COLL;
      S_COLL:   state_d = S_APPLY;
      S_APPLY:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_DRAW_LINK;
      S_DRAW_LINK: begin
        if (bus.link_draw_done || timeout_hit) begin
          frame_count_d = frame_count_q + 8'd1;
          state_d       = S_IDLE;
          if (!bus.link_draw_done) timeout_err_d = ON;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = S_WAIT_START;
    endcase
    // Strobes are registered from the next state so they line up with the
    // state register while depending on no input combinationally.
    strobes_d = decode_strobes(state_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_WAIT_START;
      to_cnt_q      <= '0;
      strobes_q     <= '0;
      frame_count_q <= '0;
      timeout_err_q <= OFF;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      strobes_q     <= strobes_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.init         = strobes_q.init;
  assign bus.idle         = strobes_q.idle;
  assign bus.draw_map     = strobes_q.draw_map;
  assign bus.reg_action   = strobes_q.reg_action;
  assign bus.apply_action = strobes_q.apply_action;
  assign bus.draw_link    = strobes_q.draw_link;
  assign bus.vga_sel      = strobes_q.vga_sel;
  assign bus.frame_count  = frame_count_q;
  assign bus.timeout_err  = timeout_err_q;
  assign dbg_state        = state_q;

endmodule
